// File: rtl/sync_trace_decoder_if.sv
// sync_trace_decoder_if: trace record stream from the decoder to a consumer.
interface sync_trace_decoder_if;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_pc;
    logic [7:0]  o_opcode;
    logic [3:0]  o_cycles;
    modport master (output o_valid, o_pc, o_opcode, o_cycles, input i_ready);
    modport slave (input o_valid, o_pc, o_opcode, o_cycles, output i_ready);
endinterface

// File: rtl/sync_trace_decoder.sv
// sync_trace_decoder: turns 6502 SYNC fetches into {pc, opcode, cycles} records queued in a FIFO.
module sync_trace_decoder #(
    parameter int DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_sync,
    input  logic                        i_rdy,
    input  logic                        i_rw,
    input  logic [15:0]                 i_address,
    input  logic [7:0]                  i_data,
    sync_trace_decoder_if.master        trace,
    output logic [7:0]                  o_dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [27:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        open;
    logic [15:0] pc_reg;
    logic [7:0]  op_reg;
    logic [3:0]  cnt;
    logic        fetch, push, pop, empty, full, accept;

    assign fetch  = i_sync & i_rdy & i_rw;
    assign push   = fetch & open;
    assign empty  = wr_ptr == rd_ptr;
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop    = !empty & trace.i_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign accept = push & (!full | pop);

    assign trace.o_valid  = !empty;
    assign trace.o_pc     = empty ? 16'h0 : mem[rd_ptr[AW-1:0]][27:12];
    assign trace.o_opcode = empty ? 8'h0 : mem[rd_ptr[AW-1:0]][11:4];
    assign trace.o_cycles = empty ? 4'h0 : mem[rd_ptr[AW-1:0]][3:0];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            open      <= 1'b0;
            pc_reg    <= '0;
            op_reg    <= '0;
            cnt       <= '0;
            o_dropped <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr[AW-1:0]] <= {pc_reg, op_reg, cnt};
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !accept && o_dropped != 8'hFF)
                o_dropped <= o_dropped + 8'd1;
            // Stalled cycles (i_rdy=0) neither count nor start a new record.
            if (fetch) begin
                pc_reg <= i_address;
                op_reg <= i_data;
                cnt    <= 4'd1;
                open   <= 1'b1;
            end else if (i_rdy && open) begin
                cnt <= (cnt == 4'hF) ? cnt : cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_sync_trace_decoder.sv
// tb_sync_trace_decoder: directed vectors for sync_trace_decoder with hand-computed records.
module tb_sync_trace_decoder;
    logic        i_clk = 1'b0;
    logic        i_reset, i_sync, i_rdy, i_rw;
    logic [15:0] i_address;
    logic [7:0]  i_data;
    logic [7:0]  o_dropped;
    int          n_checks = 0;
    int          n_fail = 0;

    sync_trace_decoder_if tr ();

    sync_trace_decoder #(.DEPTH(4)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_sync    (i_sync),
        .i_rdy     (i_rdy),
        .i_rw      (i_rw),
        .i_address (i_address),
        .i_data    (i_data),
        .trace     (tr),
        .o_dropped (o_dropped)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic cyc(input logic s, input logic r, input logic rw, input logic [15:0] a, input logic [7:0] d);
        i_sync    = s;
        i_rdy     = r;
        i_rw      = rw;
        i_address = a;
        i_data    = d;
        @(posedge i_clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] a, input logic [7:0] d);
        cyc(1'b1, 1'b1, 1'b1, a, d);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b1, 1'b1, 16'hFFFC, 8'h00);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        idle();
        i_reset = 1'b0;
    endtask

    task automatic head(input string tag, input logic [15:0] pc, input logic [7:0] op, input logic [3:0] cy);
        check({tag, ".valid"}, 32'(tr.o_valid), 32'd1);
        check({tag, ".pc"}, 32'(tr.o_pc), 32'(pc));
        check({tag, ".opcode"}, 32'(tr.o_opcode), 32'(op));
        check({tag, ".cycles"}, 32'(tr.o_cycles), 32'(cy));
    endtask

    task automatic empty_out(input string tag);
        check({tag, ".valid"}, 32'(tr.o_valid), 32'd0);
        check({tag, ".pc"}, 32'(tr.o_pc), 32'd0);
        check({tag, ".opcode"}, 32'(tr.o_opcode), 32'd0);
        check({tag, ".cycles"}, 32'(tr.o_cycles), 32'd0);
    endtask

    initial begin
        i_reset    = 1'b1;
        tr.i_ready = 1'b0;
        do_reset();
        empty_out("reset");
        check("reset.dropped", 32'(o_dropped), 32'd0);

        // Basic capture: A9 at 8000, one extra cycle, then EA at 8002.
        fetch(16'h8000, 8'hA9);
        check("basic.valid0", 32'(tr.o_valid), 32'd0);
        idle();
        check("basic.valid1", 32'(tr.o_valid), 32'd0);
        fetch(16'h8002, 8'hEA);
        head("basic", 16'h8000, 8'hA9, 4'd2);
        idle();
        head("basic.hold", 16'h8000, 8'hA9, 4'd2);
        tr.i_ready = 1'b1;
        idle();
        tr.i_ready = 1'b0;
        empty_out("basic.popped");

        // RDY stall: three stalled SYNC cycles do not count or open records.
        do_reset();
        fetch(16'h8000, 8'hA5);
        repeat (3) cyc(1'b1, 1'b0, 1'b1, 16'h8002, 8'hB5);
        check("stall.valid", 32'(tr.o_valid), 32'd0);
        idle();
        fetch(16'h8002, 8'hB5);
        head("stall", 16'h8000, 8'hA5, 4'd2);
        tr.i_ready = 1'b1;
        idle();
        tr.i_ready = 1'b0;
        check("stall.one_record", 32'(tr.o_valid), 32'd0);

        // Back-to-back fetches give cnt=1; 20 idle cycles saturate at 15.
        do_reset();
        fetch(16'hC000, 8'h01);
        fetch(16'hC001, 8'h02);
        repeat (20) idle();
        fetch(16'hC002, 8'h03);
        head("b2b", 16'hC000, 8'h01, 4'd1);
        tr.i_ready = 1'b1;
        idle();
        tr.i_ready = 1'b0;
        head("sat", 16'hC001, 8'h02, 4'd15);
        tr.i_ready = 1'b1;
        idle();
        tr.i_ready = 1'b0;
        check("sat.drained", 32'(tr.o_valid), 32'd0);

        // Overflow: 6 fetches -> 5 records, 4 stored, 1 dropped.
        do_reset();
        for (int i = 0; i < 6; i++) fetch(16'h0100 + 16'(i), 8'h10 + 8'(i));
        check("ovf.dropped", 32'(o_dropped), 32'd1);
        tr.i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            head($sformatf("ovf.drain%0d", i), 16'h0100 + 16'(i), 8'h10 + 8'(i), 4'd1);
            idle();
        end
        tr.i_ready = 1'b0;
        empty_out("ovf.empty");
        check("ovf.dropped_hold", 32'(o_dropped), 32'd1);

        // Full FIFO with simultaneous pop and push: nothing lost.
        do_reset();
        for (int i = 0; i < 5; i++) fetch(16'h0200 + 16'(i), 8'h20 + 8'(i));
        check("full.dropped0", 32'(o_dropped), 32'd0);
        tr.i_ready = 1'b1;
        fetch(16'h0205, 8'h25);
        check("full.dropped1", 32'(o_dropped), 32'd0);
        for (int i = 1; i < 5; i++) begin
            head($sformatf("full.drain%0d", i), 16'h0200 + 16'(i), 8'h20 + 8'(i), 4'd1);
            idle();
        end
        tr.i_ready = 1'b0;
        check("full.four_entries", 32'(tr.o_valid), 32'd0);

        // Reset mid-operation discards queued and open records.
        do_reset();
        fetch(16'h0300, 8'h30);
        fetch(16'h0301, 8'h31);
        fetch(16'h0302, 8'h32);
        check("mid.queued", 32'(tr.o_valid), 32'd1);
        do_reset();
        empty_out("mid.reset");
        check("mid.dropped", 32'(o_dropped), 32'd0);
        fetch(16'h0400, 8'h40);
        empty_out("mid.first_fetch");
        fetch(16'h0401, 8'h41);
        head("mid.second_fetch", 16'h0400, 8'h40, 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
